// File: rtl/dphy_rx_hs_ctrl.sv
// dphy_rx_hs_ctrl
//   HS-entry sequencer for a 4-lane D-PHY receive wrapper (byte clock domain).
//   It synchronises the LP line states of the clock lane and of data lane 0.
//   It detects LP-11 -> LP-01 -> LP-00 and then sequences the enables:
//   termination first, then the HS receivers after a settle delay. It waits
//   for per-lane SoT detects and drops every enable when the lane returns to
//   LP-11. Data lane 0 governs all data lanes.
//
// Ports
//   clk_byte_fr_i      free-running byte clock
//   reset_byte_fr_n_i  synchronous active-low reset
//   lp_clk_rx_p/n_i    clock-lane LP receiver outputs (asynchronous)
//   lp_d0_rx_p/n_i     data-lane-0 LP receiver outputs (asynchronous)
//   sot_det_i          per-lane SoT detect pulses
//   term_clk_en_o      clock-lane termination enable
//   term_d_en_o        data termination enables (all bits equal)
//   hs_d_en_o          data HS receiver enables (all bits equal)
//   rx_active_o        SoT confirmed on all lanes, burst in progress
//   sot_err_o          one-cycle pulse on SoT timeout
//   lp_err_o           one-cycle pulse on an illegal LP sequence
//   state_o            data FSM state
module dphy_rx_hs_ctrl #(
    parameter int NUM_RX_LANE = 4,
    parameter int T_TERM_EN   = 2,
    parameter int T_HS_SETTLE = 8,
    parameter int SOT_TIMEOUT = 64
) (
    input  logic                   clk_byte_fr_i,
    input  logic                   reset_byte_fr_n_i,
    input  logic                   lp_clk_rx_p_i,
    input  logic                   lp_clk_rx_n_i,
    input  logic                   lp_d0_rx_p_i,
    input  logic                   lp_d0_rx_n_i,
    input  logic [NUM_RX_LANE-1:0] sot_det_i,
    output logic                   term_clk_en_o,
    output logic [NUM_RX_LANE-1:0] term_d_en_o,
    output logic [NUM_RX_LANE-1:0] hs_d_en_o,
    output logic                   rx_active_o,
    output logic                   sot_err_o,
    output logic                   lp_err_o,
    output logic [2:0]             state_o
);

    localparam logic [2:0] ST_STOP = 3'd0;
    localparam logic [2:0] ST_HSRQ = 3'd1;
    localparam logic [2:0] ST_LP00 = 3'd2;
    localparam logic [2:0] ST_TERM = 3'd3;
    localparam logic [2:0] ST_HS   = 3'd4;
    localparam logic [2:0] ST_RX   = 3'd5;
    localparam logic [2:0] ST_ESC  = 3'd6;

    localparam logic [1:0] C_STOP = 2'd0;
    localparam logic [1:0] C_RQ   = 2'd1;
    localparam logic [1:0] C_HS   = 2'd2;

    // LP line states as {p,n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] TERM_LAST   = 8'(T_TERM_EN - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(T_HS_SETTLE - 1);
    localparam logic [7:0] SOT_LAST    = 8'(SOT_TIMEOUT - 1);

    logic [3:0]             lp_meta_p0;
    logic [3:0]             lp_sync_p1;
    logic [1:0]             lp_c;
    logic [1:0]             lp_d;
    logic [2:0]             d_state;
    logic [2:0]             d_nxt;
    logic [1:0]             c_state;
    logic [1:0]             c_nxt;
    logic [7:0]             cnt;
    logic [NUM_RX_LANE-1:0] sticky;
    logic [NUM_RX_LANE-1:0] sticky_nxt;
    logic                   lp_err_nxt;
    logic                   sot_err_nxt;

    // Stage p0/p1: two-flop synchroniser, idles at LP-11
    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            lp_meta_p0 <= 4'hF;
            lp_sync_p1 <= 4'hF;
        end else begin
            lp_meta_p0 <= {lp_clk_rx_p_i, lp_clk_rx_n_i, lp_d0_rx_p_i, lp_d0_rx_n_i};
            lp_sync_p1 <= lp_meta_p0;
        end
    end

    assign lp_c = lp_sync_p1[3:2];
    assign lp_d = lp_sync_p1[1:0];

    always_comb begin
        c_nxt = c_state;
        case (c_state)
            C_STOP: if (lp_c == LP01) c_nxt = C_RQ;
            C_RQ: begin
                if (lp_c == LP11 || lp_c == LP10) c_nxt = C_STOP;
                else if (lp_c == LP00)            c_nxt = C_HS;
            end
            C_HS:    if (lp_c == LP11) c_nxt = C_STOP;
            default: c_nxt = C_STOP;
        endcase
    end

    // LP-11 is tested first in every state so it always wins.
    always_comb begin
        d_nxt       = d_state;
        lp_err_nxt  = 1'b0;
        sot_err_nxt = 1'b0;
        sticky_nxt  = sticky;
        case (d_state)
            ST_STOP: begin
                if (lp_d == LP01)      d_nxt = ST_HSRQ;
                else if (lp_d == LP10) d_nxt = ST_ESC;
            end
            ST_HSRQ: begin
                if (lp_d == LP11) d_nxt = ST_STOP;
                else if (lp_d == LP10) begin
                    d_nxt      = ST_STOP;
                    lp_err_nxt = 1'b1;
                end else if (lp_d == LP00) d_nxt = ST_LP00;
            end
            ST_LP00: begin
                if (lp_d == LP11) d_nxt = ST_STOP;
                else if (lp_d != LP00) begin
                    d_nxt      = ST_STOP;
                    lp_err_nxt = 1'b1;
                end else if (cnt == TERM_LAST) d_nxt = ST_TERM;
            end
            ST_TERM: begin
                if (lp_d == LP11)              d_nxt = ST_STOP;
                else if (cnt == SETTLE_LAST)   d_nxt = ST_HS;
            end
            ST_HS: begin
                // Include this cycle's detects so the final lane moves to RX
                // on the edge that registers it; a simultaneous timeout loses.
                sticky_nxt = sticky | sot_det_i;
                if (lp_d == LP11)           d_nxt = ST_STOP;
                else if (&sticky_nxt)       d_nxt = ST_RX;
                else if (cnt == SOT_LAST)   sot_err_nxt = 1'b1;
            end
            ST_RX, ST_ESC: if (lp_d == LP11) d_nxt = ST_STOP;
            default: d_nxt = ST_STOP;
        endcase
    end

    // Stage p2: state, counter and registered outputs (decoded from next state)
    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            d_state       <= ST_STOP;
            c_state       <= C_STOP;
            cnt           <= 8'd0;
            sticky        <= '0;
            term_clk_en_o <= 1'b0;
            term_d_en_o   <= '0;
            hs_d_en_o     <= '0;
            rx_active_o   <= 1'b0;
            sot_err_o     <= 1'b0;
            lp_err_o      <= 1'b0;
        end else begin
            d_state <= d_nxt;
            c_state <= c_nxt;
            // Saturation keeps the HS timeout from firing a second time.
            if (d_nxt != d_state)  cnt <= 8'd0;
            else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (d_nxt == ST_HS && d_state != ST_HS) sticky <= '0;
            else                                    sticky <= sticky_nxt;
            term_clk_en_o <= (c_nxt == C_HS);
            term_d_en_o   <= {NUM_RX_LANE{(d_nxt == ST_TERM) || (d_nxt == ST_HS) || (d_nxt == ST_RX)}};
            hs_d_en_o     <= {NUM_RX_LANE{(d_nxt == ST_HS) || (d_nxt == ST_RX)}};
            rx_active_o   <= (d_nxt == ST_RX);
            sot_err_o     <= sot_err_nxt;
            lp_err_o      <= lp_err_nxt;
        end
    end

    assign state_o = d_state;

endmodule

// File: tb/tb_dphy_rx_hs_ctrl.sv
module tb_dphy_rx_hs_ctrl;

    localparam int NL   = 4;
    localparam int TT   = 2;
    localparam int THS  = 8;
    localparam int TSOT = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lp_cp, lp_cn, lp_dp, lp_dn;
    logic [NL-1:0] sot;
    logic          term_clk_en;
    logic [NL-1:0] term_d_en;
    logic [NL-1:0] hs_d_en;
    logic          rx_active;
    logic          sot_err;
    logic          lp_err;
    logic [2:0]    state;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dphy_rx_hs_ctrl #(
        .NUM_RX_LANE(NL),
        .T_TERM_EN  (TT),
        .T_HS_SETTLE(THS),
        .SOT_TIMEOUT(TSOT)
    ) dut (
        .clk_byte_fr_i    (clk),
        .reset_byte_fr_n_i(rst_n),
        .lp_clk_rx_p_i    (lp_cp),
        .lp_clk_rx_n_i    (lp_cn),
        .lp_d0_rx_p_i     (lp_dp),
        .lp_d0_rx_n_i     (lp_dn),
        .sot_det_i        (sot),
        .term_clk_en_o    (term_clk_en),
        .term_d_en_o      (term_d_en),
        .hs_d_en_o        (hs_d_en),
        .rx_active_o      (rx_active),
        .sot_err_o        (sot_err),
        .lp_err_o         (lp_err),
        .state_o          (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got === 32'(exp)) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected enables follow directly from the documented state meaning.
    task automatic chk_outs(input string tag, input int st, input bit tce, input bit serr, input bit lerr);
        bit term_on, hs_on;
        term_on = (st == 3) || (st == 4) || (st == 5);
        hs_on   = (st == 4) || (st == 5);
        chk({tag, " state"},   32'(state),       st);
        chk({tag, " term_d"},  32'(term_d_en),   term_on ? 15 : 0);
        chk({tag, " hs_d"},    32'(hs_d_en),     hs_on ? 15 : 0);
        chk({tag, " rx_act"},  32'(rx_active),   (st == 5) ? 1 : 0);
        chk({tag, " term_clk"},32'(term_clk_en), int'(tce));
        chk({tag, " sot_err"}, 32'(sot_err),     int'(serr));
        chk({tag, " lp_err"},  32'(lp_err),      int'(lerr));
    endtask

    task automatic set_pins(input logic [1:0] c, input logic [1:0] d);
        {lp_cp, lp_cn} = c;
        {lp_dp, lp_dn} = d;
    endtask

    // One burst on a relative timeline: data LP-01 driven at cycle 0, LP-00 at
    // cycle a, LP-11 at cycle e. Lane k pulses SoT at cycle p[k] (-1 = never).
    // Clock lane: LP-01 at c1, LP-00 at c0, LP-11 at ce. Expected outputs
    // come from event times: each LP change takes effect 3 cycles after it is
    // driven, and SoT pulses count only once the HS state has been entered.
    task automatic burst(input string tag, input int a, input int e,
                         input int p0, input int p1, input int p2, input int p3,
                         input int c1, input int c0, input int ce);
        int p[4];
        int lp00_t, term_t, hs_t, rx_t, last, rmax;
        bit all_ok;
        p      = '{p0, p1, p2, p3};
        lp00_t = a + 3;
        term_t = lp00_t + TT;
        hs_t   = term_t + THS;
        all_ok = 1'b1;
        last   = 0;
        for (int k = 0; k < NL; k++) begin
            if (p[k] < hs_t || p[k] >= e) all_ok = 1'b0;
            else if (p[k] > last)         last = p[k];
        end
        rx_t = all_ok ? last + 1 : 32'h3fff_ffff;
        rmax = ((e > ce) ? e : ce) + 6;
        for (int r = 0; r <= rmax; r++) begin
            int st;
            @(posedge clk);
            #1;
            if (r >= e + 3)       st = 0;
            else if (r >= rx_t)   st = 5;
            else if (r >= hs_t)   st = 4;
            else if (r >= term_t) st = 3;
            else if (r >= lp00_t) st = 2;
            else if (r >= 3)      st = 1;
            else                  st = 0;
            chk_outs($sformatf("%s r%0d", tag, r), st,
                     (r >= c0 + 3) && (r < ce + 3),
                     (r == hs_t + TSOT) && (r < rx_t) && (r < e + 3), 1'b0);
            set_pins((r < c1) ? 2'b11 : (r < c0) ? 2'b01 : (r < ce) ? 2'b00 : 2'b11,
                     (r < a) ? 2'b01 : (r < e) ? 2'b00 : 2'b11);
            for (int k = 0; k < NL; k++) sot[k] = (p[k] == r) && (r < e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_pins(2'b11, 2'b11);
        sot = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_outs("idle", 0, 1'b0, 1'b0, 1'b0);

        // LP-00 driven at relative cycle 4; offsets below are +4 from the
        // cycle numbers quoted relative to LP-00.
        burst("nominal",  4, 44, 24, 24, 24, 24, 0, 4, 44);
        burst("skew",     4, 44, 24, 26, 27, 29, 0, 4, 44);
        burst("timeout",  4, 94, -1, -1, -1, -1, 0, 4, 10);
        burst("sot_tie",  4, 94, 80, 80, 70, 60, 0, 4, 10);
        burst("sot_late", 4, 94, 81, 50, 60, 70, 0, 4, 10);
        burst("pre_hs",   4, 60, 16, 24, 24, 24, 0, 4, 10);

        // Illegal LP-10 while counting in LP00
        for (int r = 0; r <= 12; r++) begin
            @(posedge clk);
            #1;
            chk_outs($sformatf("ill_lp00 r%0d", r), (r == 3) ? 1 : (r == 4) ? 2 : 0,
                     1'b0, 1'b0, r == 5);
            set_pins(2'b11, (r == 0) ? 2'b01 : (r == 1) ? 2'b00 : (r == 2) ? 2'b10 : 2'b11);
        end

        // Illegal LP-10 straight after the request
        for (int r = 0; r <= 10; r++) begin
            @(posedge clk);
            #1;
            chk_outs($sformatf("ill_hsrq r%0d", r), (r == 3) ? 1 : 0, 1'b0, 1'b0, r == 4);
            set_pins(2'b11, (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11);
        end

        // Escape entry waits for LP-11
        for (int r = 0; r <= 15; r++) begin
            @(posedge clk);
            #1;
            chk_outs($sformatf("esc r%0d", r), (r >= 3 && r < 12) ? 6 : 0, 1'b0, 1'b0, 1'b0);
            set_pins(2'b11, (r < 9) ? 2'b10 : 2'b11);
        end

        // Clock lane alone, data lane idle
        for (int r = 0; r <= 16; r++) begin
            @(posedge clk);
            #1;
            chk_outs($sformatf("clk_only r%0d", r), 0, (r >= 5 && r < 13), 1'b0, 1'b0);
            set_pins((r < 2) ? 2'b01 : (r < 10) ? 2'b00 : 2'b11, 2'b11);
        end

        // Clock request aborted by LP-10; the later LP-00 must be ignored
        for (int r = 0; r <= 12; r++) begin
            @(posedge clk);
            #1;
            chk_outs($sformatf("clk_abort r%0d", r), 0, 1'b0, 1'b0, 1'b0);
            set_pins((r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r < 6) ? 2'b00 : 2'b11, 2'b11);
        end

        // Reset mid-RX: reset sampled at edge 21
        for (int r = 0; r <= 30; r++) begin
            int st;
            @(posedge clk);
            #1;
            if (r >= 21)      st = 0;
            else if (r >= 16) st = 5;
            else if (r >= 14) st = 4;
            else if (r >= 6)  st = 3;
            else if (r >= 4)  st = 2;
            else if (r == 3)  st = 1;
            else              st = 0;
            chk_outs($sformatf("rst_mid r%0d", r), st, 1'b0, 1'b0, 1'b0);
            rst_n = (r != 20);
            set_pins(2'b11, (r == 0) ? 2'b01 : (r < 25) ? 2'b00 : 2'b11);
            sot = (r == 15) ? 4'hF : 4'h0;
        end
        sot = '0;
        burst("after_rst", 4, 44, 24, 24, 24, 24, 0, 4, 44);

        // Randomised bursts
        for (int n = 0; n < 40; n++) begin
            int a, e, c1, c0, ce, hs_t;
            int p[4];
            a    = $urandom_range(1, 5);
            e    = a + 1 + $urandom_range(0, 120);
            hs_t = a + 3 + TT + THS;
            for (int k = 0; k < NL; k++)
                p[k] = ($urandom_range(0, 4) == 0) ? -1 : hs_t - 3 + $urandom_range(0, 90);
            c1 = $urandom_range(0, 5);
            c0 = c1 + 1 + $urandom_range(0, 3);
            ce = c0 + 1 + $urandom_range(0, 110);
            burst($sformatf("rnd%0d", n), a, e, p[0], p[1], p[2], p[3], c1, c0, ce);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dphy_rx_hs_ctrl.md
# dphy_rx_hs_ctrl

Lane-control sequencer for the 4-lane D-PHY receive wrapper. It watches the low-power (LP) line states of the clock lane and data lanes, and detects the HS-request sequence LP-11 → LP-01 → LP-00. It then drives the termination and HS-receiver enables with programmed settle delays, confirms start-of-transmission from the per-lane SoT detect vector, and tears everything down when the lanes return to LP-11. It sits between the PHY wrapper's LP/SoT outputs and its term/hs enable inputs, and runs in the free-running byte clock domain.

## Interface

Parameters:
- NUM_RX_LANE, 4: number of active data lanes (1..4).
- T_TERM_EN, 2: cycles in LP-00 before data termination is enabled (1..255).
- T_HS_SETTLE, 8: cycles with termination on before HS receivers are enabled (1..255).
- SOT_TIMEOUT, 64: cycles in HS wait before a SoT error is flagged (1..255).

Ports:
- clk_byte_fr_i, input, 1: free-running byte clock; the only clock.
- reset_byte_fr_n_i, input, 1: reset, synchronous, active-low.
- lp_clk_rx_p_i / lp_clk_rx_n_i, input, 1 each: clock-lane LP receiver outputs (asynchronous).
- lp_d0_rx_p_i / lp_d0_rx_n_i, input, 1 each: data-lane-0 LP receiver outputs (asynchronous); lane 0 governs all data lanes.
- sot_det_i, input, NUM_RX_LANE: per-lane SoT detect pulses.
- term_clk_en_o, output, 1: clock-lane termination enable.
- term_d_en_o, output, NUM_RX_LANE: data termination enables, all bits equal.
- hs_d_en_o, output, NUM_RX_LANE: data HS receiver enables, all bits equal.
- rx_active_o, output, 1: SoT confirmed on all lanes and burst in progress.
- sot_err_o, output, 1: one-cycle pulse on SoT timeout.
- lp_err_o, output, 1: one-cycle pulse on an illegal LP sequence.
- state_o, output, 3: data FSM state.

## Operation

- All four LP inputs pass through a 2-flop synchronizer; every FSM decision uses the synchronized values only. LP-xy notation means {p,n}.

Clock-lane FSM:
- States: C_STOP, C_RQ, C_HS.
- C_STOP → C_RQ on LP-01.
- C_RQ → C_HS on LP-00.
- C_RQ → C_STOP on LP-11 or LP-10.
- C_HS → C_STOP on LP-11.
- term_clk_en_o = 1 only in C_HS.

Data FSM (state_o encoding in brackets):
- STOP [0]:
  - LP-01 → HSRQ.
  - LP-10 → ESC.
  - All other states are ignored.
- HSRQ [1]:
  - LP-00 → LP00.
  - LP-11 → STOP.
  - LP-10 → STOP with a lp_err_o pulse.
- LP00 [2]:
  - Counter starts at 0 on entry. When the counter reaches T_TERM_EN-1 → TERM.
  - LP-01 or LP-10 → STOP with a lp_err_o pulse.
  - LP-11 → STOP.
- TERM [3]:
  - term_d_en_o is all ones.
  - Counter restarts at 0. When it reaches T_HS_SETTLE-1 → HS.
  - LP-11 → STOP. Other LP values are ignored.
- HS [4]:
  - term_d_en_o and hs_d_en_o are all ones.
  - The sticky per-lane OR of sot_det_i is cleared on entry. When all NUM_RX_LANE bits are set → RX.
  - Counter restarts at 0. When it reaches SOT_TIMEOUT-1, pulse sot_err_o once and stay in HS; the counter saturates and does not re-pulse.
  - LP-11 → STOP.
- RX [5]:
  - Same enables as HS, and rx_active_o = 1.
  - LP-11 → STOP (end of burst).
- ESC [6]:
  - Escape mode is not supported; the FSM waits.
  - LP-11 → STOP.

Rules common to both FSMs:
- LP-11 has priority over every other transition in every state.
- In HS, a SoT completion and the timeout can land in the same cycle. SoT wins: go to RX with no error pulse.
- The counter is 8 bits wide and clears on every state change.
- Codes 7 of the data FSM and any unused codes of the clock FSM recover to their STOP state.

## Timing

- Reset (reset_byte_fr_n_i = 0 at a clock edge) puts both FSMs in STOP and clears the synchronizer to LP-11, the sticky SoT register and the counter.
- Reset values of all outputs are 0, with state_o = 0.
- A reset asserted mid-burst drops all enables on the next edge.
- A pin change is visible at the synchronizer output 2 cycles later; the FSM reacts on the following edge.
- All outputs are registered and change on the same edge as the state.
- Pin LP-00 at cycle 0 (with LP-01 held long enough beforehand) gives:
  - state LP00 at cycle 3;
  - term_d_en_o at cycle 3 + T_TERM_EN;
  - hs_d_en_o at cycle 3 + T_TERM_EN + T_HS_SETTLE.
- Pin LP-11 at cycle 0 gives all enables low at cycle 3.
- sot_det_i is registered into the sticky set; RX is entered 1 cycle after the last lane bit is set.

## Test plan

- Nominal burst, defaults: pins LP-11→01 (hold 4)→00 at cycle 0. Expect term_d_en_o = 4'hF at cycle 5 and hs_d_en_o = 4'hF at cycle 13. Pulse sot_det_i = 4'hF at cycle 20 → rx_active_o = 1 at cycle 21. Pins LP-11 at cycle 40 → all outputs 0 at cycle 43.
- Skewed SoT: lanes report at cycles 20, 22, 23, 25 → RX at cycle 26. No sot_err_o.
- SoT timeout: no sot_det_i after HS entry at cycle 13 → single sot_err_o pulse at cycle 77, state_o stays 4. LP-11 → STOP.
- Illegal sequence: LP-01→00→10 during LP00 → one lp_err_o pulse, state_o = 0, term_d_en_o never asserted. LP-10 from STOP → state_o = 6 until LP-11.
- Clock lane: LP-11→01→00 on the clock pins → term_clk_en_o = 1 three cycles after LP-00. LP-11 → 0 three cycles later, independent of the data FSM.
- Reset mid-RX: deassert reset_byte_fr_n_i for one cycle → every output is 0 on the next edge, state_o = 0. A new HS request sequence is accepted afterwards.
